key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream conditioning stage for the DE0-Nano push-button (KEY, active-low, raw and asynchronous).
- Synchronises and debounces the button, then produces a clean level plus single-cycle press, release and long-press strobes.
- Also maintains a wrapping press counter.
- Outputs feed the LED display/shift stage, which uses them as reset, step or mode controls instead of the raw KEY.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a level change (20 ms at 50 MHz); legal range ≥2.
- LONG_CYCLES, 50000000, debounced-held cycles before long_pulse fires (1 s); legal range > DEBOUNCE_CYCLES.
- CNT_W, 26, width of the debounce and hold counters; must satisfy 2^CNT_W > LONG_CYCLES.

Ports:
- CLOCK_50  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high.
- KEY  in  1  raw button, 0 = pressed, asynchronous.
- key_level  out  1  debounced state, 1 = pressed.
- press_pulse  out  1  one-cycle strobe on accepted press.
- release_pulse  out  1  one-cycle strobe on accepted release.
- long_pulse  out  1  one-cycle strobe once per press when hold reaches LONG_CYCLES.
- press_count  out  8  number of accepted presses, modulo 256.

Behaviour:
- Reset: all outputs 0, including press_count = 0. Both sync flops load 1 (released), so reset never causes a spurious press. FSM goes to IDLE, counters and long_done clear.
- Synchroniser: 2-FF chain on KEY. key_sync = ~stage2, so it is 1 when pressed.
- Edge 0 is the first rising edge that captures KEY low. key_sync goes high after edge 1.
- All outputs are registered. Pulses are high for exactly one cycle.
- FSM states: IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT, REL_CONFIRM.
- IDLE: when key_sync = 1, go to PRESS_WAIT and set db_cnt = 0.
- PRESS_WAIT:
  - key_sync = 0 → IDLE (bounce rejected, no pulse).
  - Otherwise db_cnt increments each cycle.
  - When db_cnt = DEBOUNCE_CYCLES-1 and key_sync = 1 → PRESSED: press_pulse = 1, key_level = 1, press_count += 1 (255 wraps to 0), hold_cnt = 0.
  - Resulting latency: press_pulse goes high at edge DEBOUNCE_CYCLES+2.
- PRESSED:
  - hold_cnt increments each cycle.
  - When hold_cnt = LONG_CYCLES-1: long_pulse = 1 and long_done = 1. Next state is LONG_HELD if key_sync = 1, else RELEASE_WAIT.
  - Long-press evaluation has priority over a simultaneous release; both take effect.
  - Otherwise key_sync = 0 → RELEASE_WAIT with db_cnt = 0.
- LONG_HELD: hold_cnt is frozen. key_sync = 0 → RELEASE_WAIT with db_cnt = 0.
- RELEASE_WAIT:
  - key_sync = 1 → return to LONG_HELD if long_done, else PRESSED. hold_cnt resumes from its frozen value; it does not restart.
  - Otherwise db_cnt increments.
  - When db_cnt = DEBOUNCE_CYCLES-1 with key_sync = 0 → REL_CONFIRM.
  - hold_cnt is frozen throughout RELEASE_WAIT.
- REL_CONFIRM (single cycle): release_pulse = 1, key_level = 0, long_done = 0, then → IDLE.
- key_level stays 1 from the press_pulse cycle through the cycle before release_pulse.
- press_pulse, long_pulse and release_pulse are never high in the same cycle.
- Reset mid-operation: immediate return to reset values; no pulses in the reset cycle.
  - If KEY is held through reset deassert, a fresh debounce runs and press_pulse fires DEBOUNCE_CYCLES+2 edges after the first post-reset capture.
- Counters never overflow: db_cnt clears on every state entry, and hold_cnt is bounded by LONG_CYCLES.

Decomposition:
- Package key_debounce_pkg:
  - FSM state enum (3-bit encoding).
  - Default constants: DEBOUNCE_CYCLES_DFLT, LONG_CYCLES_DFLT, CNT_W_DFLT.
  - CLK_HZ = 50000000.
- Sub-module sync_2ff (parameter RESET_VAL): reusable 2-flop synchroniser with synchronous reset, also used elsewhere for other board inputs.
- FSM, counters and output registers stay in key_debounce.

Test Plan (DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20 unless noted):
- Clean press, then KEY = 0 held 10 cycles → press_pulse high exactly at edge 6; key_level = 1 from edge 6; press_count = 1. Then KEY = 1 held 10 cycles → release_pulse one cycle; key_level = 0.
- Bounce: KEY toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → no pulse; key_level and press_count stay 0.
- Long press: KEY = 0 for 40 cycles → press_pulse at edge 6 and long_pulse exactly once, 20 cycles after press_pulse. On release: release_pulse only, no second long_pulse.
- Release glitch: while PRESSED, KEY = 1 for 2 cycles then 0 again → no release_pulse; key_level stays 1; hold_cnt frozen during the glitch; long_pulse is later delayed by the glitch cycles.
- Wrap: 256 clean press/release cycles → press_count returns to 0 with exactly 256 press_pulses.
- Reset: assert reset mid-PRESS_WAIT and again mid-PRESSED with KEY held → outputs 0 during reset; press_pulse at edge 6 after the post-reset capture; press_count = 1.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the push-button conditioning stage.
package key_debounce_pkg;

  localparam int unsigned CLK_HZ               = 50000000;
  localparam int unsigned DEBOUNCE_CYCLES_DFLT = 1000000;
  localparam int unsigned LONG_CYCLES_DFLT     = 50000000;
  localparam int unsigned CNT_W_DFLT           = 26;

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StPressed,
    StLongHeld,
    StReleaseWait,
    StRelConfirm
  } state_e;

endpackage

// File: rtl/key_debounce_if.sv
// Conditioned button outputs handed from the debouncer to the display/shift stage.
interface key_debounce_if;

  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  modport master (
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output press_count
  );

  modport slave (
    input key_level,
    input press_pulse,
    input release_pulse,
    input long_pulse,
    input press_count
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, synchronous active-high reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic stage1_q;
  logic stage2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_q <= RESET_VAL;
      stage2_q <= RESET_VAL;
    end else begin
      stage1_q <= din;
      stage2_q <= stage1_q;
    end
  end

  assign dout = stage2_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces the active-low KEY into a clean level plus press/release/long strobes
// and a wrapping press counter.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DFLT,
  parameter int unsigned CNT_W           = CNT_W_DFLT
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           KEY,
  key_debounce_if.master btn
);

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);

  logic             key_raw;
  logic             key_sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_done_q, long_done_d;
  logic             key_level_q, key_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             long_pulse_q, long_pulse_d;
  logic [7:0]       press_count_q, press_count_d;

  // Flops reset to the released level so reset can never look like a press.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (CLOCK_50),
    .reset(reset),
    .din  (KEY),
    .dout (key_raw)
  );

  assign key_sync = ~key_raw;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= StIdle;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      long_done_q     <= 1'b0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      press_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_done_q     <= long_done_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      press_count_q   <= press_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (key_sync) state_d = StPressWait;
      StPressWait: begin
        if (!key_sync)                state_d = StIdle;
        else if (db_cnt_q == DbLast)  state_d = StPressed;
      end
      // Long-press check wins over a release seen in the same cycle.
      StPressed: begin
        if (hold_cnt_q == LongLast)   state_d = key_sync ? StLongHeld : StReleaseWait;
        else if (!key_sync)           state_d = StReleaseWait;
      end
      StLongHeld:  if (!key_sync) state_d = StReleaseWait;
      StReleaseWait: begin
        if (key_sync)                 state_d = long_done_q ? StLongHeld : StPressed;
        else if (db_cnt_q == DbLast)  state_d = StRelConfirm;
      end
      StRelConfirm: state_d = StIdle;
      default:      state_d = StIdle;
    endcase

    db_cnt_d = db_cnt_q;
    if (state_d != state_q) begin
      db_cnt_d = '0;
    end else if (state_q == StPressWait || state_q == StReleaseWait) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    // hold_cnt only advances while in PRESSED, so release glitches delay the long press.
    hold_cnt_d = hold_cnt_q;
    if (state_q == StPressWait && state_d == StPressed) begin
      hold_cnt_d = '0;
    end else if (state_q == StPressed && hold_cnt_q != LongLast) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    long_done_d = long_done_q;
    if (state_q == StPressed && hold_cnt_q == LongLast) begin
      long_done_d = 1'b1;
    end else if (state_q == StRelConfirm) begin
      long_done_d = 1'b0;
    end
  end

  always_comb begin
    press_pulse_d   = (state_q == StPressWait) && (state_d == StPressed);
    long_pulse_d    = (state_q == StPressed) && (hold_cnt_q == LongLast);
    release_pulse_d = (state_q == StReleaseWait) && (state_d == StRelConfirm);

    key_level_d = key_level_q;
    if (press_pulse_d) begin
      key_level_d = 1'b1;
    end else if (release_pulse_d) begin
      key_level_d = 1'b0;
    end

    press_count_d = press_count_q + 8'(press_pulse_d);
  end

  assign btn.key_level     = key_level_q;
  assign btn.press_pulse   = press_pulse_q;
  assign btn.release_pulse = release_pulse_q;
  assign btn.long_pulse    = long_pulse_q;
  assign btn.press_count   = press_count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_key_debounce;

  logic CLOCK_50 = 1'b0;
  logic reset;
  logic KEY;

  int total = 0;
  int bad = 0;
  int press_seen = 0;
  int long_seen = 0;
  int rel_seen = 0;
  int overlap = 0;
  int p0, l0, r0;

  key_debounce_if btn ();

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .CNT_W          (8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .KEY     (KEY),
    .btn     (btn)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (btn.press_pulse === 1'b1) press_seen++;
    if (btn.long_pulse === 1'b1) long_seen++;
    if (btn.release_pulse === 1'b1) rel_seen++;
    if (({1'b0, btn.press_pulse} + {1'b0, btn.long_pulse} + {1'b0, btn.release_pulse}) > 2'd1)
      overlap++;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, 16'(btn.key_level), 16'd0);
    chk({tag, "_press"}, 16'(btn.press_pulse), 16'd0);
    chk({tag, "_release"}, 16'(btn.release_pulse), 16'd0);
    chk({tag, "_long"}, 16'(btn.long_pulse), 16'd0);
    chk({tag, "_count"}, 16'(btn.press_count), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    KEY   = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Clean press then release
    KEY = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_press_pulse", 16'(btn.press_pulse), 16'(k == 6));
      chk("t1_key_level", 16'(btn.key_level), 16'(k >= 6));
    end
    chk("t1_count", 16'(btn.press_count), 16'd1);
    KEY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_release_pulse", 16'(btn.release_pulse), 16'(k == 6));
      chk("t1_rel_level", 16'(btn.key_level), 16'(k < 6));
    end

    // Bounce: toggling every 2 cycles never qualifies
    p0 = press_seen;
    for (int k = 0; k < 20; k++) begin
      KEY = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      chk("bounce_level", 16'(btn.key_level), 16'd0);
      chk("bounce_press", 16'(btn.press_pulse), 16'd0);
    end
    KEY = 1'b1;
    repeat (6) tick();
    chk("bounce_count", 16'(btn.press_count), 16'd1);
    chk("bounce_no_press", 16'(press_seen - p0), 16'd0);

    // Long press
    l0 = long_seen;
    KEY = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("long_press_pulse", 16'(btn.press_pulse), 16'(k == 6));
      chk("long_long_pulse", 16'(btn.long_pulse), 16'(k == 26));
      chk("long_level", 16'(btn.key_level), 16'(k >= 6));
    end
    KEY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("long_release_pulse", 16'(btn.release_pulse), 16'(k == 6));
      chk("long_no_second", 16'(btn.long_pulse), 16'd0);
    end
    chk("long_once", 16'(long_seen - l0), 16'd1);
    chk("long_count", 16'(btn.press_count), 16'd2);

    // Release glitch while PRESSED delays the long press by two cycles
    l0 = long_seen;
    r0 = rel_seen;
    for (int k = 0; k < 40; k++) begin
      KEY = (k == 10 || k == 11) ? 1'b1 : 1'b0;
      tick();
      chk("glitch_press_pulse", 16'(btn.press_pulse), 16'(k == 6));
      chk("glitch_release", 16'(btn.release_pulse), 16'd0);
      chk("glitch_level", 16'(btn.key_level), 16'(k >= 6));
      chk("glitch_long_pulse", 16'(btn.long_pulse), 16'(k == 28));
    end
    chk("glitch_no_release", 16'(rel_seen - r0), 16'd0);
    KEY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_release_pulse", 16'(btn.release_pulse), 16'(k == 6));
    end
    chk("glitch_long_once", 16'(long_seen - l0), 16'd1);
    chk("glitch_count", 16'(btn.press_count), 16'd3);

    // Reset mid PRESS_WAIT with KEY held
    KEY = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) begin
      tick();
      chk_zero("rst_pw");
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_pw_press_pulse", 16'(btn.press_pulse), 16'(k == 6));
      chk("rst_pw_level", 16'(btn.key_level), 16'(k >= 6));
    end
    chk("rst_pw_count", 16'(btn.press_count), 16'd1);

    // Reset mid PRESSED with KEY held
    reset = 1'b1;
    repeat (2) begin
      tick();
      chk_zero("rst_pr");
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_pr_press_pulse", 16'(btn.press_pulse), 16'(k == 6));
    end
    chk("rst_pr_count", 16'(btn.press_count), 16'd1);
    KEY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_pr_release_pulse", 16'(btn.release_pulse), 16'(k == 6));
    end

    // Counter wrap over 256 presses
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p0 = press_seen;
    l0 = long_seen;
    for (int i = 0; i < 256; i++) begin
      KEY = 1'b0;
      repeat (8) tick();
      KEY = 1'b1;
      repeat (8) tick();
      if (i == 254) chk("wrap_count_255", 16'(btn.press_count), 16'd255);
    end
    chk("wrap_count_0", 16'(btn.press_count), 16'd0);
    chk("wrap_presses", 16'(press_seen - p0), 16'd256);
    chk("wrap_no_long", 16'(long_seen - l0), 16'd0);
    chk("pulse_overlap", 16'(overlap), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
